// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: circular instruction/PC buffer between fetch and decode, with head decode-field slices.
package inst_fetch_queue_pkg;
  typedef logic [6:0] opcode_t;
  typedef logic [2:0] func3_t;
  typedef logic [6:0] func7_t;
endpackage

module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  output opcode_t           out_opcode,
  output func3_t            out_func3,
  output func7_t            out_func7,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [CNT_W-1:0]  count
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign in_ready  = count != CNT_W'(DEPTH);
  assign out_valid = count != '0;
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
      count  <= count + CNT_W'(push) - CNT_W'(pop);
    end
  always_ff @(posedge clk)
    if (push) begin
      pc_mem[wr_ptr]   <= in_pc;
      inst_mem[wr_ptr] <= in_inst;
    end
  always_comb begin
    out_pc     = out_valid ? pc_mem[rd_ptr] : '0;
    out_inst   = out_valid ? inst_mem[rd_ptr] : '0;
    out_opcode = out_inst[6:0];
    out_rd     = out_inst[11:7];
    out_func3  = out_inst[14:12];
    out_rs1    = out_inst[19:15];
    out_rs2    = out_inst[24:20];
    out_func7  = out_inst[31:25];
  end
endmodule
